// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined logarithmic shifter (SLL/SRL/SRA, ROR when SHIFTER_PIPE_ROTATE_EN is defined)

module shifter_pipe #(
    parameter  int WIDTH  = 32,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] in_amt,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef SHIFTER_PIPE_ROTATE_EN
    localparam logic [1:0] MODE_ROR = 2'b11;
`endif

    // Index k holds the state registered at the end of stage k.
    logic [STAGES-1:0][WIDTH-1:0]  data_q,  data_d;
    logic [STAGES-1:0][STAGES-1:0] amt_q,   amt_d;
    logic [STAGES-1:0][1:0]        mode_q,  mode_d;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic                          advance;

    // The whole pipe moves as one unit: it stalls only when the last slot
    // holds a result that downstream refuses. Bubbles travel as invalid slots.
    assign advance   = out_ready | ~valid_q[STAGES-1];
    assign in_ready  = advance;

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_zero  = (data_q[STAGES-1] == '0);

    // The final stage has no further amount bits or mode to consume.
    logic unused_tail;
    assign unused_tail = ^{amt_q[STAGES-1], mode_q[STAGES-1]};

    // Stage k shifts by the weight of amount bit STAGES-1-k (largest step first).
    always_comb begin
        logic [WIDTH-1:0]  cur;
        logic [STAGES-1:0] amt;
        logic [1:0]        mode;
        logic              vld;
        int                prev;
        int                sh;
        data_d  = '0;
        amt_d   = '0;
        mode_d  = '0;
        valid_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                cur  = in_data;
                amt  = in_amt;
                mode = in_mode;
                vld  = in_valid;
            end else begin
                cur  = data_q[prev];
                amt  = amt_q[prev];
                mode = mode_q[prev];
                vld  = valid_q[prev];
            end
            sh = 1 << (STAGES - 1 - k);
            if (amt[STAGES-1-k]) begin
                case (mode)
                    MODE_SLL: cur = cur << sh;
                    MODE_SRL: cur = cur >> sh;
                    // SRA keeps the MSB intact, so each stage sees the original sign bit.
                    MODE_SRA: cur = $unsigned($signed(cur) >>> sh);
`ifdef SHIFTER_PIPE_ROTATE_EN
                    MODE_ROR: cur = (cur >> sh) | (cur << (WIDTH - sh));
`endif
                    // Without rotate support, mode 11 behaves as a logical right shift.
                    default:  cur = cur >> sh;
                endcase
            end
            amt[STAGES-1-k] = 1'b0;
            data_d[k]  = cur;
            amt_d[k]   = amt;
            mode_d[k]  = mode;
            valid_d[k] = vld;
        end
    end

    // Stage registers: cleared by reset, loaded together whenever the pipe advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            valid_q <= '0;
        end else if (advance) begin
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are powers of two from 2 to 64.
REQ-002 SHALL have derived parameter STAGES, default log2(WIDTH), giving the shift-amount width and the pipeline depth; it SHALL NOT be overridden.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, input beat present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts an input beat this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits, operand.
REQ-008 SHALL have port in_amt, input, STAGES bits, unsigned shift amount.
REQ-009 SHALL have port in_mode, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 SHALL have port out_valid, output, 1 bit, result present.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-012 SHALL have port out_data, output, WIDTH bits, shifted result.
REQ-013 SHALL have port out_zero, output, 1 bit, high when out_data is all zeros; qualified by out_valid.

Function
REQ-014 SHALL implement a logarithmic shifter of STAGES stages; stage k (k=0 first) shifts by 2^(STAGES-1-k) when amount bit STAGES-1-k is set, otherwise it passes the value through.
REQ-015 SHALL register the data, remaining amount bits, mode and a valid bit after every stage, giving STAGES pipeline registers.
REQ-016 SHALL define advance = out_ready OR NOT out_valid; every stage register SHALL load only when advance is high.
REQ-017 SHALL drive in_ready = advance combinationally; a beat is accepted when in_valid AND in_ready.
REQ-018 SHALL present an accepted beat on out_valid exactly STAGES cycles after acceptance when advance stays high; each stall cycle adds exactly one cycle.
REQ-019 SHALL sustain one beat per cycle under continuous in_valid and out_ready; bubbles advance as invalid slots and SHALL NOT be compressed.
REQ-020 SHALL hold out_data, out_zero and out_valid stable while out_valid is high and out_ready is low.
REQ-021 SHALL fill vacated MSBs with zero for SRL, fill vacated MSBs with the original in_data[WIDTH-1] for SRA, and fill vacated LSBs with zero for SLL.
REQ-022 SHALL feed bits shifted out of the LSB end back into the MSB end for ROR.
REQ-023 SHALL return in_data unchanged for in_amt = 0 in every mode.
REQ-024 SHALL produce results for in_amt = WIDTH-1 according to REQ-021 and REQ-022, with no saturation or wrap special case.
REQ-025 SHALL treat simultaneous input acceptance and output consumption in one cycle as a normal advance, with no beat lost or duplicated.

Reset
REQ-026 SHALL asynchronously clear every stage valid bit to 0 while reset_n is low, so that out_valid = 0.
REQ-027 SHALL clear out_data to 0 while reset_n is low, and out_zero SHALL read 1.
REQ-028 SHALL discard all in-flight beats when reset is asserted mid-operation; no result from before reset SHALL appear after release.
REQ-029 SHALL have in_ready = 1 on the first cycle after reset release.

Configuration
REQ-030 SHALL compile ROR logic only when macro SHIFTER_PIPE_ROTATE_EN is defined; with it, mode 11 behaves per REQ-022.
REQ-031 SHALL treat mode 11 exactly as SRL (01) when SHIFTER_PIPE_ROTATE_EN is undefined, and SHALL contain no rotate wiring in that build.

Verification (WIDTH=32, STAGES=5)
REQ-032 SHALL verify: SRA 0x80000000 amt 4 -> 0xF8000000; SRL same operand -> 0x08000000; SLL 0x00000001 amt 31 -> 0x80000000; each 5 cycles after accept.
REQ-033 SHALL verify: with ROTATE_EN, mode 11 on 0x00000001 amt 1 -> 0x80000000; without it, the same stimulus -> 0x00000000 and out_zero = 1.
REQ-034 SHALL verify: amt 0 in all four modes on 0xDEADBEEF -> 0xDEADBEEF.
REQ-035 SHALL verify: 8 back-to-back beats with out_ready = 1 -> 8 results on 8 consecutive cycles, in order, starting at cycle 5.
REQ-036 SHALL verify: out_ready low for 3 cycles while out_valid is high -> out_data held stable, in_ready = 0, no beat dropped after release.
REQ-037 SHALL verify: reset_n pulsed low with 3 beats in flight -> out_valid = 0 immediately, and no stale result appears after release.
